load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 37 +++
 rtl/lsu_align.sv | 38 +++
 rtl/load_store_unit.sv | 133 +++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, RV32I size codes and defaults.
// Used by load_store_unit and lsu_align.
package lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

    // Unsigned loads have no store counterpart.
    function automatic logic funct3_legal(input logic write, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !write;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store data replication, load lane select and extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;
    logic        sx;

    always_comb begin
        shifted = rdata_i >> {off_i, 3'b000};
        sx      = !funct3_i[2];
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{sx & shifted[7]}}, shifted[7:0]};
            end
            2'b01: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{sx & shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access, req/gnt/rvalid memory port, timeout abort.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of forcing them aligned.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e  state_q, state_d;
    logic        write_q;
    logic [2:0]  f3_q;
    logic [31:2] addr_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [TW-1:0] tmo_q;

    logic        req_mis;
    logic        req_bad;
    logic [1:0]  req_off;
    logic        tmo_expired;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    assign req_mis = is_misaligned(req_funct3, req_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
    assign req_bad = !funct3_legal(req_write, req_funct3) || req_mis;
    assign req_off = req_addr[1:0];
`else
    assign req_bad = !funct3_legal(req_write, req_funct3);
    assign req_off = req_mis ? 2'b00 : req_addr[1:0];
`endif

    assign tmo_expired = (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    lsu_align u_align (
        .funct3_i (f3_q),
        .off_i    (off_q),
        .wdata_i  (wdata_q),
        .rdata_i  (mem_rdata),
        .be_o     (lane_be),
        .wdata_o  (lane_wdata),
        .rdata_o  (lane_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_valid) state_d = req_bad ? ST_RESP : ST_REQ;
            ST_REQ:  if (mem_gnt) state_d = ST_WAIT;
            ST_WAIT: if (mem_rvalid || tmo_expired) state_d = ST_RESP;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            write_q <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: if (req_valid) begin
                    write_q <= req_write;
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr[31:2];
                    off_q   <= req_off;
                    wdata_q <= req_wdata;
                    err_q   <= req_bad;
                    rdata_q <= '0;
                end
                ST_REQ: tmo_q <= '0;
                ST_WAIT: begin
                    // rvalid wins over a timeout landing in the same cycle.
                    if (mem_rvalid) begin
                        rdata_q <= write_q ? '0 : lane_rdata;
                    end else if (tmo_expired) begin
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-side outputs are only driven while requesting so idle/reset values stay zero.
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
        rsp_err   = rsp_valid & err_q;
        rsp_rdata = rsp_valid ? rdata_q : '0;
        mem_req   = (state_q == ST_REQ);
        mem_we    = mem_req & write_q;
        mem_addr  = mem_req ? {addr_q, 2'b00} : '0;
        mem_wdata = mem_req ? lane_wdata : '0;
        mem_be    = mem_req ? lane_be : '0;
    end

endmodule
